// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Contents:
//   rf_state_t          - clear-sweep controller states
//   RF_WIDTH/RF_DEPTH/RF_NRD - default geometry
//   rf_aw()             - address width for a given depth (at least 1 bit)
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_WIDTH = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_NRD   = 2;

    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode stage and the register file.
// Signals:
//   we0/wa0/wd0      - write port 0 (ALU writeback)
//   we1/wa1/wd1      - write port 1 (load/mult writeback), wins on address clash
//   ra / rd / pend   - packed read addresses, read data, pending bits (NRD ports)
//   mark_en/mark_addr- set the pending bit of one register
//   clr_req / busy   - start a clear sweep / sweep in progress
// Modports: master (decode side), slave (register file).
interface regfile_mp_if import regfile_pkg::*; #(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int NRD   = RF_NRD,
    localparam int AW   = rf_aw(DEPTH)
) ();

    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [WIDTH-1:0]     wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [WIDTH-1:0]     wd1;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       pend;
    logic                 mark_en;
    logic [AW-1:0]        mark_addr;
    logic                 clr_req;
    logic                 busy;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra, mark_en, mark_addr, clr_req,
        input  rd, pend, busy
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra, mark_en, mark_addr, clr_req,
        output rd, pend, busy
    );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller: walks the register array zeroing one entry per
// cycle, DEPTH cycles in total.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   clr_req         - start request, honoured only when idle
//   busy            - high while the sweep runs
//   sweep_we/addr   - zero-write strobe and target register
//   pend_clr        - one-cycle pulse on sweep entry; clears every pending bit
module regfile_clear_ctrl import regfile_pkg::*; #(
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr,
    output logic          pend_clr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RF_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        sweep_we  = 1'b0;
        pend_clr  = 1'b0;
        case (state)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt = RF_CLEAR;
                    cnt_nxt   = '0;
                    // Pending bits drop on the same edge the sweep starts.
                    pend_clr  = 1'b1;
                end
            end
            RF_CLEAR: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = RF_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = RF_IDLE;
        endcase
    end

    assign sweep_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage.
//   - Two write ports, port 1 has priority on an address clash.
//   - NRD combinational read ports with optional same-cycle write bypass.
//   - Per-register pending (scoreboard) bits: mark sets, write clears,
//     mark beats a simultaneous write.
//   - Clear sweep (regfile_clear_ctrl) zeroes the array over DEPTH cycles;
//     writes, marks and bypass are suppressed while it runs.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   bus         - regfile_mp_if slave modport (write/read/mark/clear)
//   dbg_addr/dbg_data - non-bypassed array tap, present only when
//                       REGFILE_DEBUG_EN is defined
module regfile_mp import regfile_pkg::*; #(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = RF_NRD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    regfile_mp_if.slave    bus
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
`endif
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend_q;

    logic             busy;
    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;
    logic             pend_clr;

    logic [AW-1:0]    wa0, wa1, mark_addr;
    logic [WIDTH-1:0] wd0, wd1;
    logic             w0_ok, w1_ok, mark_ok;

    // Address exists and is not the hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] a);
        if (!addr_ok(a))
            return '0;
        if (BYPASS != 0) begin
            if (w1_ok && (wa1 == a))
                return wd1;
            if (w0_ok && (wa0 == a))
                return wd0;
        end
        return mem[a];
    endfunction

    function automatic logic read_pend(input logic [AW-1:0] a);
        if (!addr_ok(a))
            return 1'b0;
        // A forwarded write has already cleared the bit unless a mark lands too.
        if ((BYPASS != 0) && ((w1_ok && (wa1 == a)) || (w0_ok && (wa0 == a))))
            return mark_ok && (mark_addr == a);
        return pend_q[a];
    endfunction

    regfile_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (bus.clr_req),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .pend_clr   (pend_clr)
    );

    assign wa0       = bus.wa0;
    assign wa1       = bus.wa1;
    assign wd0       = bus.wd0;
    assign wd1       = bus.wd1;
    assign mark_addr = bus.mark_addr;

    assign w0_ok   = bus.we0     && !busy && addr_ok(wa0);
    assign w1_ok   = bus.we1     && !busy && addr_ok(wa1);
    assign mark_ok = bus.mark_en && !busy && addr_ok(mark_addr);

    assign bus.busy = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sweep_we && (sweep_addr == AW'(i)))
                    mem[i] <= '0;
                else if (w1_ok && (wa1 == AW'(i)))
                    mem[i] <= wd1;
                else if (w0_ok && (wa0 == AW'(i)))
                    mem[i] <= wd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else if (pend_clr) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mark_ok && (mark_addr == AW'(i)))
                    pend_q[i] <= 1'b1;
                else if ((w0_ok && (wa0 == AW'(i))) || (w1_ok && (wa1 == AW'(i))))
                    pend_q[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rd   = '0;
        bus.pend = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.rd[k*WIDTH +: WIDTH] = read_data(bus.ra[k*AW +: AW]);
            bus.pend[k]              = read_pend(bus.ra[k*AW +: AW]);
        end
    end

`ifdef REGFILE_DEBUG_EN
    always_comb begin
        dbg_data = '0;
        if (reset && addr_ok(dbg_addr))
            dbg_data = mem[dbg_addr];
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: instance A (DEPTH=32, BYPASS=1) and
// instance B (DEPTH=24, BYPASS=0), both with ZERO_REG=1.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   busy_n;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) bus_a ();
    regfile_mp_if #(.WIDTH(32), .DEPTH(24), .NRD(2)) bus_b ();

`ifdef REGFILE_DEBUG_EN
    logic [4:0]  dbg_addr_a = 5'd0;
    logic [31:0] dbg_data_a;
    logic [4:0]  dbg_addr_b = 5'd0;
    logic [31:0] dbg_data_b;
`endif

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_addr (dbg_addr_a),
        .dbg_data (dbg_data_a)
`endif
    );

    regfile_mp #(.WIDTH(32), .DEPTH(24), .NRD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
`ifdef REGFILE_DEBUG_EN
        ,
        .dbg_addr (dbg_addr_b),
        .dbg_data (dbg_data_b)
`endif
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        mk;
        logic [4:0]  ma;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ep0;
        logic        ep1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mv(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic mk, input logic [4:0] ma,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic ep0, input logic ep1);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.mk  = mk;  v.ma  = ma;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e0  = e0;  v.e1  = e1;
        v.ep0 = ep0; v.ep1 = ep1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.we0 = 1'b0; bus_a.wa0 = '0; bus_a.wd0 = '0;
        bus_a.we1 = 1'b0; bus_a.wa1 = '0; bus_a.wd1 = '0;
        bus_a.mark_en = 1'b0; bus_a.mark_addr = '0; bus_a.clr_req = 1'b0;
        bus_b.we0 = 1'b0; bus_b.wa0 = '0; bus_b.wd0 = '0;
        bus_b.we1 = 1'b0; bus_b.wa1 = '0; bus_b.wd1 = '0;
        bus_b.mark_en = 1'b0; bus_b.mark_addr = '0; bus_b.clr_req = 1'b0;
    endtask

    task automatic apply_a(input vec_t v);
        bus_a.we0 = v.we0; bus_a.wa0 = v.wa0; bus_a.wd0 = v.wd0;
        bus_a.we1 = v.we1; bus_a.wa1 = v.wa1; bus_a.wd1 = v.wd1;
        bus_a.mark_en = v.mk; bus_a.mark_addr = v.ma;
        bus_a.ra = {v.ra1, v.ra0};
    endtask

    task automatic count_busy(input string nm);
        busy_n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!bus_a.busy) break;
            busy_n++;
            step();
        end
        check(nm, 32'(busy_n), 32'd32);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Table: state entering row 0 is r5=DEADBEEF, everything else 0.
        vecs[0]  = mv(1'b1,5'd7,32'h11, 1'b1,5'd7,32'h22, 1'b0,5'd0, 5'd7,5'd5, 32'h22,32'hDEADBEEF, 1'b0,1'b0);
        vecs[1]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd7,5'd0, 32'h22,32'h0,        1'b0,1'b0);
        vecs[2]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b1,5'd9, 5'd9,5'd7, 32'h0,32'h22,        1'b0,1'b0);
        vecs[3]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd7, 32'h0,32'h22,        1'b1,1'b0);
        vecs[4]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd7, 32'h0,32'h22,        1'b1,1'b0);
        vecs[5]  = mv(1'b0,5'd0,32'h0,  1'b1,5'd9,32'hABCD, 1'b0,5'd0, 5'd9,5'd7, 32'hABCD,32'h22,   1'b0,1'b0);
        vecs[6]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd7, 32'hABCD,32'h22,     1'b0,1'b0);
        vecs[7]  = mv(1'b1,5'd9,32'h77, 1'b0,5'd0,32'h0,  1'b1,5'd9, 5'd9,5'd7, 32'h77,32'h22,       1'b1,1'b0);
        vecs[8]  = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd7, 32'h77,32'h22,       1'b1,1'b0);
        vecs[9]  = mv(1'b1,5'd0,32'h55, 1'b0,5'd0,32'h0,  1'b1,5'd0, 5'd0,5'd9, 32'h0,32'h77,        1'b0,1'b1);
        vecs[10] = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd0,5'd9, 32'h0,32'h77,        1'b0,1'b1);
        vecs[11] = mv(1'b1,5'd3,32'h33, 1'b1,5'd4,32'h44, 1'b0,5'd0, 5'd3,5'd4, 32'h33,32'h44,       1'b0,1'b0);
        vecs[12] = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd3,5'd4, 32'h33,32'h44,       1'b0,1'b0);
        vecs[13] = mv(1'b1,5'd9,32'h99, 1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd9, 32'h99,32'h99,       1'b0,1'b0);
        vecs[14] = mv(1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  1'b0,5'd0, 5'd9,5'd9, 32'h99,32'h99,       1'b0,1'b0);

        idle_all();
        bus_a.ra = '0;
        bus_b.ra = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("init_busy", 32'(bus_a.busy), 32'd0);
        check("init_rd0", bus_a.rd[31:0], 32'd0);
        step();
        step();
        reset = 1'b1;

        // Some activity, then reset dropped between clock edges.
        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd5; bus_a.wd0 = 32'h1234;
        step();
        idle_all();
        bus_a.ra = {5'd6, 5'd5};
        #1 check("pre_rst_wr", bus_a.rd[31:0], 32'h1234);
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd6;
        step();
        idle_all();
        #1 check("pre_rst_mark", 32'(bus_a.pend[1]), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_rd0", bus_a.rd[31:0], 32'd0);
        check("rst_pend1", 32'(bus_a.pend[1]), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        step();
        reset = 1'b1;

        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd5; bus_a.wd0 = 32'hDEADBEEF;
        step();
        idle_all();
        bus_a.ra = {5'd0, 5'd5};
        #1 check("wr_r5", bus_a.rd[31:0], 32'hDEADBEEF);
        step();

        for (int i = 0; i < NV; i++) begin
            apply_a(vecs[i]);
            #1;
            check($sformatf("vec%0d_rd0", i), bus_a.rd[31:0], vecs[i].e0);
            check($sformatf("vec%0d_rd1", i), bus_a.rd[63:32], vecs[i].e1);
            check($sformatf("vec%0d_pend0", i), 32'(bus_a.pend[0]), 32'(vecs[i].ep0));
            check($sformatf("vec%0d_pend1", i), 32'(bus_a.pend[1]), 32'(vecs[i].ep1));
            step();
        end
        idle_all();

        // Instance B: no bypass, DEPTH=24.
        bus_b.we0 = 1'b1; bus_b.wa0 = 5'd7; bus_b.wd0 = 32'h11;
        bus_b.we1 = 1'b1; bus_b.wa1 = 5'd7; bus_b.wd1 = 32'h22;
        bus_b.ra = {5'd0, 5'd7};
        #1 check("nobyp_old", bus_b.rd[31:0], 32'd0);
        step();
        idle_all();
        #1 check("nobyp_new", bus_b.rd[31:0], 32'h22);
        bus_b.we0 = 1'b1; bus_b.wa0 = 5'd30; bus_b.wd0 = 32'h5A;
        bus_b.mark_en = 1'b1; bus_b.mark_addr = 5'd30;
        bus_b.ra = {5'd23, 5'd30};
        step();
        idle_all();
        #1;
        check("oob_rd", bus_b.rd[31:0], 32'd0);
        check("oob_pend", 32'(bus_b.pend[0]), 32'd0);
        bus_b.we1 = 1'b1; bus_b.wa1 = 5'd23; bus_b.wd1 = 32'h23;
        bus_b.mark_en = 1'b1; bus_b.mark_addr = 5'd23;
        #1 check("b_wr_cycle", bus_b.rd[63:32], 32'd0);
        step();
        idle_all();
        #1;
        check("b_r23", bus_b.rd[63:32], 32'h23);
        check("b_mark_wins", 32'(bus_b.pend[1]), 32'd1);
        bus_b.we0 = 1'b1; bus_b.wa0 = 5'd0; bus_b.wd0 = 32'h55;
        step();
        idle_all();
        bus_b.ra = {5'd0, 5'd0};
        #1 check("b_r0", bus_b.rd[31:0], 32'd0);
        step();

        // Fill A with all ones, mark r12, then sweep.
        for (int i = 0; i < 32; i += 2) begin
            bus_a.we0 = 1'b1; bus_a.wa0 = 5'(i);     bus_a.wd0 = 32'hFFFF_FFFF;
            bus_a.we1 = 1'b1; bus_a.wa1 = 5'(i + 1); bus_a.wd1 = 32'hFFFF_FFFF;
            step();
        end
        idle_all();
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd12;
        step();
        idle_all();
        bus_a.ra = {5'd31, 5'd12};
        #1;
        check("pre_clr_pend", 32'(bus_a.pend[0]), 32'd1);
        check("fill_r12", bus_a.rd[31:0], 32'hFFFF_FFFF);
        bus_a.clr_req = 1'b1;
        step();
        bus_a.clr_req = 1'b0;
        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd2; bus_a.wd0 = 32'h1;
        bus_a.mark_en = 1'b1; bus_a.mark_addr = 5'd12;
        busy_n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!bus_a.busy) break;
            busy_n++;
            if (c == 5) begin
                bus_a.wa0 = 5'd20; bus_a.wd0 = 32'h5;
                bus_a.ra = {5'd20, 5'd4};
                #1;
                check("sweep_r4_done", bus_a.rd[31:0], 32'd0);
                check("sweep_nobyp", bus_a.rd[63:32], 32'hFFFF_FFFF);
                bus_a.wa0 = 5'd2; bus_a.wd0 = 32'h1;
            end
            bus_a.clr_req = (c == 10);
            step();
        end
        check("busy_len", 32'(busy_n), 32'd32);
        idle_all();
        bus_a.ra = {5'd12, 5'd2};
        #1;
        check("sweep_wr_dropped", bus_a.rd[31:0], 32'd0);
        check("sweep_pend_clr", 32'(bus_a.pend[1]), 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus_a.ra = {5'd0, 5'(i)};
            #1 check($sformatf("swept_r%0d", i), bus_a.rd[31:0], 32'd0);
        end
        step();

        // Reset in the middle of a sweep.
        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd30; bus_a.wd0 = 32'hFF;
        step();
        idle_all();
        bus_a.clr_req = 1'b1;
        step();
        bus_a.clr_req = 1'b0;
        repeat (10) step();
        bus_a.ra = {5'd0, 5'd30};
        #1 check("mid_sweep_r30", bus_a.rd[31:0], 32'hFF);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_clear", bus_a.rd[31:0], 32'd0);
        step();
        reset = 1'b1;
        step();
        check("abort_idle", 32'(bus_a.busy), 32'd0);
        bus_a.we0 = 1'b1; bus_a.wa0 = 5'd30; bus_a.wd0 = 32'hFF;
        step();
        idle_all();
        bus_a.clr_req = 1'b1;
        step();
        bus_a.clr_req = 1'b0;
        count_busy("busy_len2");
        #1 check("resweep_r30", bus_a.rd[31:0], 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-cycle 3-port register file.
- Configurable width, depth and read-port count; two write ports with fixed priority.
- Optional write-to-read bypass; per-register pending (scoreboard) bits for outstanding loads/multi-cycle results; sequential clear sweep driven by a small FSM.
- Sits in the decode stage of the pipelined MIPS datapath, replacing the flat regfile.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; AW = $clog2(DEPTH).
- NRD, 2, number of combinational read ports.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1, when 1, same-cycle write data is forwarded to read ports.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  AW  write address, port 0.
- wd0  in  WIDTH  write data, port 0.
- we1  in  1  write enable, port 1 (load/mult writeback).
- wa1  in  AW  write address, port 1.
- wd1  in  WIDTH  write data, port 1.
- ra  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd  out  NRD*WIDTH  packed read data.
- pend  out  NRD  pending bit of each ra[k].
- mark_en  in  1  set pending bit for mark_addr.
- mark_addr  in  AW  register to mark pending.
- clr_req  in  1  single-cycle pulse that starts a clear sweep.
- busy  out  1  high while a clear sweep runs.

Behaviour:
- Reset (reset=0, async): all registers 0, all pending bits 0, FSM RF_IDLE, sweep counter 0, busy=0. rd reflects the cleared array.
- Writes commit on the rising clk edge. If we0 and we1 target the same address in the same cycle, port 1 wins.
- Addresses >= DEPTH (non-power-of-2 DEPTH): writes and marks are ignored; reads return 0 and pend returns 0.
- ZERO_REG=1: address 0 reads 0, pend=0, and writes/marks to it are dropped.
- Reads are combinational, with 0-cycle latency.
- BYPASS=1: if ra[k] matches an enabled write address in RF_IDLE, rd[k] returns that write data (port 1 priority) and pend[k]=0 unless mark_en hits the same address.
- BYPASS=0: reads return array contents only, so new data is visible the cycle after the write.
- Pending: a write on either port clears the bit for its address. mark_en sets the bit. If a mark and a write hit the same address in the same cycle, the mark wins (bit ends up 1).
- FSM RF_IDLE -> RF_CLEAR on clr_req. On entry, all pending bits clear and the counter is 0.
- RF_CLEAR: writes 0 to register[counter] each cycle and increments the counter. busy=1. we0/we1/mark_en are ignored. clr_req is ignored.
- After register DEPTH-1 is written, the FSM returns to RF_IDLE and busy drops the next cycle. Total busy duration is exactly DEPTH cycles.
- Reads during a sweep return current array contents (already-swept registers read 0). No bypass applies during a sweep.
- Reset asserted mid-sweep aborts the sweep immediately to the reset state.

Optional Feature:
- Macro: REGFILE_DEBUG_EN.
- Defined: adds ports dbg_addr (in, AW) and dbg_data (out, WIDTH). dbg_data is a combinational, non-bypassed array read. It is 0 while reset=0 and 0 for address 0 when ZERO_REG=1. This generalises the fixed v0 debug tap.
- Undefined: the ports and logic are absent; no other behaviour changes.

Decomposition:
- Package regfile_pkg: enum rf_state_t {RF_IDLE, RF_CLEAR}; default constants RF_WIDTH=32, RF_DEPTH=32, RF_NRD=2.
- Sub-module regfile_clear_ctrl: FSM plus sweep counter. Outputs busy, the sweep write enable/address, and a one-cycle pending-clear pulse.
- Array, write priority, bypass and pending logic live in regfile_mp.

Test Plan:
- Reset low mid-operation, then high -> all rd=0, pend=0, busy=0 immediately while low; write 0xDEADBEEF to r5 then read r5 -> 0xDEADBEEF.
- we0 r7=0x11, we1 r7=0x22 in the same cycle, ra[0]=7 -> rd[0]=0x22 combinationally (BYPASS=1); next cycle r7=0x22. Repeat with BYPASS=0 -> old value in the write cycle, 0x22 after.
- mark r9, then we1 r9=0xABCD two cycles later -> pend[0]=1 for 2 cycles, then 0 in the write cycle (bypass). Mark r9 and write r9 in the same cycle -> pend stays 1.
- Write all regs 0xFFFF_FFFF, pulse clr_req -> busy high exactly DEPTH(32) cycles; r0..r(n-1) read 0 progressively; writes during the sweep are dropped; all pend=0.
- Assert reset at sweep cycle 10 -> busy=0 asynchronously, all regs 0, FSM idle; a new clr_req works normally.
- Write r0=0x55 with ZERO_REG=1 -> rd=0, pend=0; with DEPTH=24, write r30 -> ignored, read r30 -> 0.
